// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer
// Job-level controller for a single PE MAC core. It clears the PE accumulator,
// streams vec_len operand pairs into the PE, waits for the last term to land,
// captures the PE output and offers it on a valid/ready result port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; job parameters latched on start
// CLEAR   | reg_reset high for this one cycle, PE accumulator clears
// RUN     | accepting operands; each handshake fires pe_en next cycle
// DRAIN   | last term's pe_en is high, accumulator takes final term
// CAPTURE | pe_results registered into res_data at end of cycle
// OUT     | res_valid high, res_data held until res_ready

module pe_mac_sequencer #(
    parameter int W_IN  = 8,
    parameter int W_ACC = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             relu_en,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [W_IN-1:0]  op_a,
    input  logic [W_IN-1:0]  op_b,
    output logic             pe_en,
    output logic             mode_sel,
    output logic             reg_reset,
    output logic [W_IN-1:0]  a_mul,
    output logic [W_IN-1:0]  b_mul,
    input  logic [W_ACC-1:0] pe_results,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W_ACC-1:0] res_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    state_t             state_q, state_d;

    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   cnt_inc;

    logic               pe_en_q, pe_en_d;
    logic               mode_sel_q, mode_sel_d;
    logic               reg_reset_q, reg_reset_d;
    logic [W_IN-1:0]    a_mul_q, a_mul_d;
    logic [W_IN-1:0]    b_mul_q, b_mul_d;
    logic               res_valid_q, res_valid_d;
    logic [W_ACC-1:0]   res_data_q, res_data_d;
    logic               done_q, done_d;

    logic               op_hs;
    logic               last_term;
    logic               abort_act;

    // Handshake and termination decode shared by the next-state and output logic
    assign op_ready  = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign op_hs     = op_valid && op_ready;
    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign last_term = (cnt_inc == len_q);
    assign abort_act = abort && (state_q != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over any same-cycle handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (len_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (op_hs && last_term) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = abort ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = abort ? S_IDLE : S_OUT;
            end
            S_OUT: begin
                if (abort || res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; abort drops everything and re-clears the PE
    always_comb begin
        len_d       = len_q;
        cnt_d       = cnt_q;
        mode_sel_d  = mode_sel_q;
        a_mul_d     = a_mul_q;
        b_mul_d     = b_mul_q;
        res_data_d  = res_data_q;
        pe_en_d     = 1'b0;
        reg_reset_d = 1'b0;
        res_valid_d = 1'b0;
        done_d      = 1'b0;

        if (abort_act) begin
            reg_reset_d = 1'b1;
            cnt_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_d       = vec_len;
                        mode_sel_d  = relu_en;
                        reg_reset_d = 1'b1;
                        cnt_d       = '0;
                    end
                end
                S_CLEAR: begin
                    cnt_d = '0;
                end
                S_RUN: begin
                    if (op_hs) begin
                        a_mul_d = op_a;
                        b_mul_d = op_b;
                        pe_en_d = 1'b1;
                        cnt_d   = cnt_inc;
                    end
                end
                S_CAPTURE: begin
                    res_data_d  = pe_results;
                    res_valid_d = 1'b1;
                end
                S_OUT: begin
                    if (res_ready) begin
                        done_d = 1'b1;
                    end else begin
                        res_valid_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs and job bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            pe_en_q     <= 1'b0;
            mode_sel_q  <= 1'b0;
            reg_reset_q <= 1'b0;
            a_mul_q     <= '0;
            b_mul_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            pe_en_q     <= pe_en_d;
            mode_sel_q  <= mode_sel_d;
            reg_reset_q <= reg_reset_d;
            a_mul_q     <= a_mul_d;
            b_mul_q     <= b_mul_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    assign pe_en     = pe_en_q;
    assign mode_sel  = mode_sel_q;
    assign reg_reset = reg_reset_q;
    assign a_mul     = a_mul_q;
    assign b_mul     = b_mul_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// tb_pe_mac_sequencer
// Drives pe_mac_sequencer with directed and random jobs. A simple PE model
// (clearable signed accumulator with optional ReLU) closes the loop, and the
// expected result of each job is computed directly from its operand list.

module tb_pe_mac_sequencer;

    localparam int W_IN  = 8;
    localparam int W_ACC = 24;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] vec_len;
    logic             relu_en;
    logic             op_valid;
    logic             op_ready;
    logic [W_IN-1:0]  op_a;
    logic [W_IN-1:0]  op_b;
    logic             pe_en;
    logic             mode_sel;
    logic             reg_reset;
    logic [W_IN-1:0]  a_mul;
    logic [W_IN-1:0]  b_mul;
    logic [W_ACC-1:0] pe_results;
    logic             res_valid;
    logic             res_ready;
    logic [W_ACC-1:0] res_data;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    int qa[$];
    int qb[$];

    pe_mac_sequencer #(.W_IN(W_IN), .W_ACC(W_ACC), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .vec_len    (vec_len),
        .relu_en    (relu_en),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .pe_en      (pe_en),
        .mode_sel   (mode_sel),
        .reg_reset  (reg_reset),
        .a_mul      (a_mul),
        .b_mul      (b_mul),
        .pe_results (pe_results),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE core model: unsigned a times signed b, wrapping signed accumulator
    logic signed [W_ACC-1:0] pe_acc;
    logic signed [W_IN*2:0]  pe_prod;
    assign pe_prod    = $signed({1'b0, a_mul}) * $signed(b_mul);
    assign pe_results = (mode_sel && pe_acc[W_ACC-1]) ? '0 : pe_acc;

    always @(posedge clk) begin
        if (rst || reg_reset) pe_acc <= '0;
        else if (pe_en)       pe_acc <= pe_acc + W_ACC'(pe_prod);
    end

    function automatic logic [W_ACC-1:0] ref_result(input bit relu);
        longint sum;
        logic [W_ACC-1:0] r;
        sum = 0;
        foreach (qa[i]) sum += longint'(qa[i]) * longint'(qb[i]);
        r = sum[W_ACC-1:0];
        if (relu && r[W_ACC-1]) r = '0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        abort     = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
    endtask

    // Runs the job held in qa/qb. Starts in the current cycle and returns in
    // the cycle where done is expected, without advancing further.
    task automatic do_job(input string tag, input bit relu, input int gap,
                          input int rdy_wait, input bit poke);
        int len, idx, wait_cnt, exp_valid_cyc, budget;
        bit prev_hs, cur_hs, pending, exp_rdy, finished;
        logic [W_ACC-1:0] exp_res;
        len           = qa.size();
        exp_res       = ref_result(relu);
        idx           = 0;
        wait_cnt      = 0;
        prev_hs       = 0;
        pending       = 0;
        finished      = 0;
        exp_valid_cyc = (len == 0) ? 3 : 1000000;
        budget        = 20 + len * 5 + rdy_wait;

        start    = 1'b1;
        vec_len  = LEN_W'(len);
        relu_en  = relu;
        op_valid = 1'b0;
        res_ready = 1'b0;
        tick();
        start    = 1'b0;
        vec_len  = LEN_W'($urandom);
        relu_en  = 1'($urandom);

        for (int cyc = 1; cyc <= budget; cyc++) begin
            exp_rdy = (len > 0) && (cyc >= 2) && (idx < len);

            n_checks++;
            if (pe_en !== prev_hs) begin
                n_fail++;
                $display("FAIL %s pe_en cyc=%0d got=%b exp=%b", tag, cyc, pe_en, prev_hs);
            end
            n_checks++;
            if (reg_reset !== (cyc == 1)) begin
                n_fail++;
                $display("FAIL %s reg_reset cyc=%0d got=%b exp=%b", tag, cyc, reg_reset, (cyc == 1));
            end
            n_checks++;
            if (mode_sel !== relu) begin
                n_fail++;
                $display("FAIL %s mode_sel cyc=%0d got=%b exp=%b", tag, cyc, mode_sel, relu);
            end
            if (idx > 0) begin
                n_checks++;
                if (a_mul !== W_IN'(qa[idx-1]) || b_mul !== W_IN'(qb[idx-1])) begin
                    n_fail++;
                    $display("FAIL %s operands cyc=%0d got=%0d,%0d exp=%0d,%0d", tag, cyc,
                             a_mul, b_mul, W_IN'(qa[idx-1]), W_IN'(qb[idx-1]));
                end
            end
            n_checks++;
            if (op_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL %s op_ready cyc=%0d got=%b exp=%b", tag, cyc, op_ready, exp_rdy);
            end

            if (pending) begin
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s done_cycle cyc=%0d got done=%b busy=%b valid=%b exp 1,0,0",
                             tag, cyc, done, busy, res_valid);
                end
                n_checks++;
                if (res_data !== exp_res) begin
                    n_fail++;
                    $display("FAIL %s res_data_after cyc=%0d got=%0d exp=%0d", tag, cyc, res_data, exp_res);
                end
                finished = 1;
                break;
            end

            n_checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_done cyc=%0d got busy=%b done=%b exp 1,0", tag, cyc, busy, done);
            end
            n_checks++;
            if (res_valid !== (cyc >= exp_valid_cyc)) begin
                n_fail++;
                $display("FAIL %s res_valid cyc=%0d got=%b exp=%b", tag, cyc, res_valid, (cyc >= exp_valid_cyc));
            end
            if (cyc >= exp_valid_cyc) begin
                n_checks++;
                if (res_data !== exp_res) begin
                    n_fail++;
                    $display("FAIL %s res_data cyc=%0d got=%0d exp=%0d", tag, cyc, res_data, exp_res);
                end
            end

            // drive this cycle's inputs
            if (exp_rdy) begin
                if (wait_cnt > 0) begin
                    op_valid = 1'b0;
                    wait_cnt--;
                end else begin
                    op_valid = 1'b1;
                    op_a     = W_IN'(qa[idx]);
                    op_b     = W_IN'(qb[idx]);
                end
            end else begin
                op_valid = 1'($urandom);
                op_a     = W_IN'($urandom);
                op_b     = W_IN'($urandom);
            end
            cur_hs = exp_rdy && op_valid;
            if (cur_hs) begin
                idx++;
                wait_cnt = (gap < 0) ? int'($urandom_range(2)) : gap;
                if (idx == len) exp_valid_cyc = cyc + 3;
            end
            if (cyc >= exp_valid_cyc) begin
                res_ready = (cyc - exp_valid_cyc >= rdy_wait);
                pending   = res_ready;
            end else begin
                res_ready = 1'($urandom);
            end
            start   = poke && (cyc % 3 == 0);
            prev_hs = cur_hs;
            tick();
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, budget);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({pe_en, mode_sel, reg_reset, a_mul, b_mul, res_valid, res_data, busy, done, op_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got pe_en=%b mode=%b rr=%b a=%0d b=%0d v=%b d=%0d busy=%b done=%b rdy=%b exp all 0",
                     pe_en, mode_sel, reg_reset, a_mul, b_mul, res_valid, res_data, busy, done, op_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        qa = '{10, 20, 255};
        qb = '{3, -2, 1};
        do_job("basic", 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_len_zero();
        qa = {};
        qb = {};
        do_job("len_zero", 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_relu();
        qa = '{5, 1};
        qb = '{-4, 1};
        do_job("relu", 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_bubbles();
        qa = '{7, 130, 33, 250};
        qb = '{-100, 45, -1, 120};
        do_job("bubbles", 1'b0, 2, 5, 1'b1);
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bubbles ignored_start got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_abort();
        qa = '{11, 22, 33, 44};
        qb = '{1, 2, 3, 4};
        start   = 1'b1;
        vec_len = 8'd4;
        relu_en = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            op_valid = 1'b1;
            op_a     = W_IN'(qa[i]);
            op_b     = W_IN'(qb[i]);
            abort    = (i == 2);
            tick();
        end
        idle_inputs();
        n_checks++;
        if (busy !== 1'b0 || reg_reset !== 1'b1 || pe_en !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next got busy=%b rr=%b pe_en=%b valid=%b rdy=%b exp 0,1,0,0,0",
                     busy, reg_reset, pe_en, res_valid, op_ready);
        end
        n_checks++;
        if (a_mul !== W_IN'(qa[1])) begin
            n_fail++;
            $display("FAIL abort_inflight a_mul got=%0d exp=%0d", a_mul, W_IN'(qa[1]));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (reg_reset !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet got rr=%b done=%b valid=%b busy=%b exp 0,0,0,0",
                         reg_reset, done, res_valid, busy);
            end
        end
        qa = '{200};
        qb = '{1};
        do_job("abort_follow", 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_rst_during(input bit in_out);
        start   = 1'b1;
        vec_len = 8'd1;
        relu_en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op_valid = 1'b1;
        op_a     = 8'd100;
        op_b     = 8'hCE;
        tick();
        op_valid = 1'b0;
        tick();
        if (in_out) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_out pre res_valid got=%b exp=1", res_valid);
            end
            res_ready = 1'b1;
            abort     = 1'b1;
        end else begin
            n_checks++;
            if (busy !== 1'b1 || res_valid !== 1'b0 || mode_sel !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_capture pre got busy=%b valid=%b mode=%b exp 1,0,1", busy, res_valid, mode_sel);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        n_checks++;
        if ({pe_en, mode_sel, reg_reset, a_mul, b_mul, res_valid, res_data, busy, done, op_ready} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid(%0d) outputs got pe_en=%b mode=%b rr=%b a=%0d b=%0d v=%b busy=%b done=%b exp all 0",
                     in_out, pe_en, mode_sel, reg_reset, a_mul, b_mul, res_valid, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid(%0d) after got done=%b busy=%b valid=%b exp 0,0,0",
                         in_out, done, busy, res_valid);
            end
        end
    endtask

    task automatic fill_random(input int len);
        qa = {};
        qb = {};
        for (int i = 0; i < len; i++) begin
            qa.push_back(int'($urandom_range(255)));
            qb.push_back(int'($urandom_range(255)) - 128);
        end
    endtask

    task automatic test_back_to_back();
        fill_random(5);
        do_job("b2b_0", 1'b0, 0, 0, 1'b0);
        fill_random(3);
        do_job("b2b_1", 1'b1, 0, 0, 1'b0);
        fill_random(6);
        do_job("b2b_2", 1'b0, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 12; j++) begin
            fill_random(int'($urandom_range(12)));
            do_job($sformatf("rand_%0d", j), 1'($urandom), -1,
                   int'($urandom_range(3)), 1'($urandom));
            if ($urandom_range(1) == 1) tick();
        end
    endtask

    initial begin
        idle_inputs();
        vec_len = '0;
        relu_en = 1'b0;
        rst     = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_len_zero();
        test_relu();
        test_bubbles();
        test_abort();
        test_rst_during(1'b0);
        test_rst_during(1'b1);
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
